// File: rtl/punc_control_ws.sv
// ============================================================================
// Module   : punc_control_ws
// Purpose  : Multi-cycle LC3 control FSM for PUnC with memory wait states and
//            a run/stall gate on instruction fetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module punc_control_ws #(
    parameter int         MEM_WAIT  = 0,
    parameter logic [7:0] HALT_VECT = 8'h25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] ir,
    input  logic [2:0]  nzp,
    output logic [1:0]  mem_r_addr_sel,
    output logic        mem_w_en,
    output logic [1:0]  mem_w_addr_sel,
    output logic        mdr_ld,
    output logic        rf_w_en,
    output logic        rf_w_addr_sel,
    output logic [1:0]  rf_w_data_sel,
    output logic        rf_r0_addr_sel,
    output logic [1:0]  alu_op,
    output logic        cc_ld,
    output logic        ir_ld,
    output logic        pc_ld,
    output logic [1:0]  pc_sel,
    output logic        halted,
    output logic        instr_done
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_IND    = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [3:0] c_OP_BR   = 4'b0000;
    localparam logic [3:0] c_OP_ADD  = 4'b0001;
    localparam logic [3:0] c_OP_LD   = 4'b0010;
    localparam logic [3:0] c_OP_ST   = 4'b0011;
    localparam logic [3:0] c_OP_JSR  = 4'b0100;
    localparam logic [3:0] c_OP_AND  = 4'b0101;
    localparam logic [3:0] c_OP_LDR  = 4'b0110;
    localparam logic [3:0] c_OP_STR  = 4'b0111;
    localparam logic [3:0] c_OP_NOT  = 4'b1001;
    localparam logic [3:0] c_OP_LDI  = 4'b1010;
    localparam logic [3:0] c_OP_STI  = 4'b1011;
    localparam logic [3:0] c_OP_JMP  = 4'b1100;
    localparam logic [3:0] c_OP_LEA  = 4'b1110;
    localparam logic [3:0] c_OP_TRAP = 4'b1111;

    localparam logic [3:0] c_MEM_LAST = 4'(MEM_WAIT);

    logic [2:0] r_state;
    logic [3:0] r_wcnt;
    logic [2:0] w_next_state;
    logic [3:0] w_next_wcnt;
    logic [3:0] w_op;
    logic       w_last;
    logic       w_mem_op;
    logic       w_ind_op;
    logic       w_fin;
    logic       w_unused;

    assign w_op     = ir[15:12];
    assign w_last   = (r_wcnt == c_MEM_LAST);
    assign w_unused = ir[8];
    assign w_ind_op = (w_op == c_OP_LDI) || (w_op == c_OP_STI);
    assign w_mem_op = (w_op == c_OP_LD)  || (w_op == c_OP_LDR) ||
                      (w_op == c_OP_ST)  || (w_op == c_OP_STR) || w_ind_op;

    always_comb begin
        mem_r_addr_sel = 2'd0;
        mem_w_en       = 1'b0;
        mem_w_addr_sel = 2'd0;
        mdr_ld         = 1'b0;
        rf_w_en        = 1'b0;
        rf_w_addr_sel  = 1'b0;
        rf_w_data_sel  = 2'd0;
        rf_r0_addr_sel = 1'b0;
        alu_op         = 2'd0;
        cc_ld          = 1'b0;
        ir_ld          = 1'b0;
        pc_ld          = 1'b0;
        pc_sel         = 2'd0;
        halted         = 1'b0;
        instr_done     = 1'b0;
        w_next_state   = r_state;
        w_next_wcnt    = r_wcnt;
        w_fin          = 1'b1;

        case (r_state)
            S_FETCH: begin
                // run only matters before the fetch access has begun
                if ((r_wcnt != 4'd0) || run) begin
                    if (w_last) begin
                        ir_ld        = 1'b1;
                        pc_ld        = 1'b1;
                        w_next_state = S_DECODE;
                        w_next_wcnt  = 4'd0;
                    end else begin
                        w_next_wcnt  = r_wcnt + 4'd1;
                    end
                end
            end
            S_DECODE: begin
                w_next_wcnt  = 4'd0;
                w_next_state = ((w_op == c_OP_TRAP) && (ir[7:0] == HALT_VECT))
                               ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                w_fin = w_mem_op ? w_last : 1'b1;
                case (w_op)
                    c_OP_ADD, c_OP_AND, c_OP_NOT: begin
                        alu_op  = (w_op == c_OP_ADD) ? 2'd0 :
                                  (w_op == c_OP_AND) ? 2'd1 : 2'd2;
                        rf_w_en = 1'b1;
                        cc_ld   = 1'b1;
                    end
                    c_OP_BR: begin
                        if ((ir[11:9] & nzp) != 3'b000) begin
                            pc_ld  = 1'b1;
                            pc_sel = 2'd1;
                        end
                    end
                    c_OP_JMP: begin
                        pc_ld  = 1'b1;
                        pc_sel = 2'd3;
                    end
                    c_OP_JSR: begin
                        rf_w_en       = 1'b1;
                        rf_w_addr_sel = 1'b1;
                        rf_w_data_sel = 2'd3;
                        pc_ld         = 1'b1;
                        pc_sel        = ir[11] ? 2'd2 : 2'd3;
                    end
                    c_OP_LEA: begin
                        rf_w_en       = 1'b1;
                        rf_w_data_sel = 2'd2;
                        cc_ld         = 1'b1;
                    end
                    c_OP_LD, c_OP_LDR: begin
                        mem_r_addr_sel = (w_op == c_OP_LD) ? 2'd1 : 2'd2;
                        rf_w_en        = w_fin;
                        rf_w_data_sel  = w_fin ? 2'd1 : 2'd0;
                        cc_ld          = w_fin;
                    end
                    c_OP_ST, c_OP_STR: begin
                        mem_w_addr_sel = (w_op == c_OP_ST) ? 2'd1 : 2'd2;
                        rf_r0_addr_sel = 1'b1;
                        alu_op         = 2'd3;
                        mem_w_en       = w_fin;
                    end
                    c_OP_LDI, c_OP_STI: begin
                        mem_r_addr_sel = 2'd1;
                        mdr_ld         = w_fin;
                    end
                    default: ;
                endcase
                if (w_fin) begin
                    w_next_wcnt  = 4'd0;
                    w_next_state = w_ind_op ? S_IND : S_FETCH;
                    instr_done   = !w_ind_op;
                end else begin
                    w_next_wcnt  = r_wcnt + 4'd1;
                end
            end
            S_IND: begin
                // second access goes through the pointer latched in MDR
                if (w_op == c_OP_LDI) begin
                    mem_r_addr_sel = 2'd3;
                    rf_w_en        = w_last;
                    rf_w_data_sel  = w_last ? 2'd1 : 2'd0;
                    cc_ld          = w_last;
                end else begin
                    mem_w_addr_sel = 2'd3;
                    rf_r0_addr_sel = 1'b1;
                    alu_op         = 2'd3;
                    mem_w_en       = w_last;
                end
                if (w_last) begin
                    w_next_wcnt  = 4'd0;
                    w_next_state = S_FETCH;
                    instr_done   = 1'b1;
                end else begin
                    w_next_wcnt  = r_wcnt + 4'd1;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next_state = S_FETCH;
                w_next_wcnt  = 4'd0;
            end
        endcase

        // Nothing may reach the datapath during a reset cycle
        if (rst) begin
            mem_r_addr_sel = 2'd0;
            mem_w_en       = 1'b0;
            mem_w_addr_sel = 2'd0;
            mdr_ld         = 1'b0;
            rf_w_en        = 1'b0;
            rf_w_addr_sel  = 1'b0;
            rf_w_data_sel  = 2'd0;
            rf_r0_addr_sel = 1'b0;
            alu_op         = 2'd0;
            cc_ld          = 1'b0;
            ir_ld          = 1'b0;
            pc_ld          = 1'b0;
            pc_sel         = 2'd0;
            halted         = 1'b0;
            instr_done     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_wcnt  <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_wcnt  <= w_next_wcnt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_punc_control_ws.sv
// ============================================================================
// Module   : tb_punc_control_ws
// Purpose  : Randomized self-checking bench for punc_control_ws, two wait-state
//            configurations, compared cycle by cycle against a sequence model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_punc_control_ws;

    typedef struct packed {
        logic [1:0] mem_r_addr_sel;
        logic       mem_w_en;
        logic [1:0] mem_w_addr_sel;
        logic       mdr_ld;
        logic       rf_w_en;
        logic       rf_w_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       rf_r0_addr_sel;
        logic [1:0] alu_op;
        logic       cc_ld;
        logic       ir_ld;
        logic       pc_ld;
        logic [1:0] pc_sel;
        logic       halted;
        logic       instr_done;
    } ctl_t;

    logic        clk;
    logic        rst_v  [2];
    logic        run_v  [2];
    logic [15:0] ir_v   [2];
    logic [2:0]  nzp_v  [2];
    ctl_t        obs    [2];
    ctl_t        exp_q  [$];

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [1:0] w_mras, w_mwas, w_wds, w_alu, w_pcs;
        logic       w_mwe, w_mdr, w_rfe, w_rfa, w_r0, w_cc, w_irl, w_pcl, w_hlt, w_done;

        punc_control_ws #(.MEM_WAIT((gi == 0) ? 0 : 2), .HALT_VECT(8'h25)) u_dut (
            .clk            (clk),
            .rst            (rst_v[gi]),
            .run            (run_v[gi]),
            .ir             (ir_v[gi]),
            .nzp            (nzp_v[gi]),
            .mem_r_addr_sel (w_mras),
            .mem_w_en       (w_mwe),
            .mem_w_addr_sel (w_mwas),
            .mdr_ld         (w_mdr),
            .rf_w_en        (w_rfe),
            .rf_w_addr_sel  (w_rfa),
            .rf_w_data_sel  (w_wds),
            .rf_r0_addr_sel (w_r0),
            .alu_op         (w_alu),
            .cc_ld          (w_cc),
            .ir_ld          (w_irl),
            .pc_ld          (w_pcl),
            .pc_sel         (w_pcs),
            .halted         (w_hlt),
            .instr_done     (w_done)
        );

        assign obs[gi] = {w_mras, w_mwe, w_mwas, w_mdr, w_rfe, w_rfa, w_wds, w_r0,
                          w_alu, w_cc, w_irl, w_pcl, w_pcs, w_hlt, w_done};
    end

    task automatic chk(input string tag, input ctl_t got, input ctl_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    // One clock: sample on the falling edge, then move just past the rising edge
    task automatic step(input int k, input ctl_t exp, input string tag);
        @(negedge clk);
        chk(tag, obs[k], exp);
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle control words for a whole instruction, fetch onward
    task automatic build(input logic [15:0] f_ir, input logic [2:0] f_nzp,
                         input int mw, output bit is_halt);
        ctl_t c, b, f, b2, f2;
        int   n;
        bit   mem, ind;
        logic [3:0] op;
        op = f_ir[15:12];
        exp_q.delete();
        is_halt = 1'b0;
        for (int i = 0; i <= mw; i++) begin
            c = '0;
            if (i == mw) begin c.ir_ld = 1'b1; c.pc_ld = 1'b1; end
            exp_q.push_back(c);
        end
        exp_q.push_back('0);
        if (op == 4'hF && f_ir[7:0] == 8'h25) begin
            is_halt = 1'b1;
            return;
        end
        b = '0; f = '0; b2 = '0; f2 = '0; mem = 1'b0; ind = 1'b0;
        case (op)
            4'h1, 4'h5, 4'h9: begin
                f.alu_op  = (op == 4'h1) ? 2'd0 : (op == 4'h5) ? 2'd1 : 2'd2;
                f.rf_w_en = 1'b1; f.cc_ld = 1'b1;
            end
            4'h0: if ((f_ir[11:9] & f_nzp) != 3'b000) begin f.pc_ld = 1'b1; f.pc_sel = 2'd1; end
            4'hC: begin f.pc_ld = 1'b1; f.pc_sel = 2'd3; end
            4'h4: begin
                f.rf_w_en = 1'b1; f.rf_w_addr_sel = 1'b1; f.rf_w_data_sel = 2'd3;
                f.pc_ld = 1'b1; f.pc_sel = f_ir[11] ? 2'd2 : 2'd3;
            end
            4'hE: begin f.rf_w_en = 1'b1; f.rf_w_data_sel = 2'd2; f.cc_ld = 1'b1; end
            4'h2, 4'h6: begin
                mem = 1'b1; b.mem_r_addr_sel = (op == 4'h2) ? 2'd1 : 2'd2;
                f.rf_w_en = 1'b1; f.rf_w_data_sel = 2'd1; f.cc_ld = 1'b1;
            end
            4'h3, 4'h7: begin
                mem = 1'b1; b.mem_w_addr_sel = (op == 4'h3) ? 2'd1 : 2'd2;
                b.rf_r0_addr_sel = 1'b1; b.alu_op = 2'd3; f.mem_w_en = 1'b1;
            end
            4'hA, 4'hB: begin
                mem = 1'b1; ind = 1'b1; b.mem_r_addr_sel = 2'd1; f.mdr_ld = 1'b1;
                if (op == 4'hA) begin
                    b2.mem_r_addr_sel = 2'd3;
                    f2.rf_w_en = 1'b1; f2.rf_w_data_sel = 2'd1; f2.cc_ld = 1'b1;
                end else begin
                    b2.mem_w_addr_sel = 2'd3; b2.rf_r0_addr_sel = 1'b1; b2.alu_op = 2'd3;
                    f2.mem_w_en = 1'b1;
                end
            end
            default: ;
        endcase
        n = mem ? mw + 1 : 1;
        for (int i = 0; i < n; i++) begin
            c = b;
            if (i == n - 1) begin
                c = ctl_t'(c | f);
                c.instr_done = !ind;
            end
            exp_q.push_back(c);
        end
        if (ind) begin
            for (int i = 0; i <= mw; i++) begin
                c = b2;
                if (i == mw) begin
                    c = ctl_t'(c | f2);
                    c.instr_done = 1'b1;
                end
                exp_q.push_back(c);
            end
        end
    endtask

    task automatic do_instr(input int k, input int mw, input logic [15:0] f_ir,
                            input logic [2:0] f_nzp);
        bit   h;
        int   stall;
        stall = $urandom_range(0, 2);
        ir_v[k]  = f_ir;
        nzp_v[k] = f_nzp;
        for (int s = 0; s < stall; s++) begin
            run_v[k] = 1'b0;
            step(k, '0, $sformatf("u%0d_stall", k));
        end
        run_v[k] = 1'b1;
        build(f_ir, f_nzp, mw, h);
        for (int i = 0; i < exp_q.size(); i++) begin
            step(k, exp_q[i], $sformatf("u%0d_ir%04h_c%0d", k, f_ir, i));
            run_v[k] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic run_stream(input int k, input int mw);
        logic [15:0] dir [18];
        logic [2:0]  dnz [18];
        logic [15:0] r_ir;
        ctl_t        hv;
        bit          h;
        dir = '{16'h1042, 16'h2005, 16'h0403, 16'h0403, 16'hA005, 16'hB005,
                16'h3205, 16'h7283, 16'h4800, 16'h4080, 16'hC1C0, 16'hE403,
                16'h6283, 16'h9A7F, 16'h5262, 16'hD000, 16'h8000, 16'hF020};
        dnz = '{3'b001, 3'b100, 3'b010, 3'b001, 3'b010, 3'b100,
                3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100,
                3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        rst_v[k] = 1'b1; run_v[k] = 1'b1; ir_v[k] = 16'h1042; nzp_v[k] = 3'b000;
        step(k, '0, $sformatf("u%0d_rst", k));
        step(k, '0, $sformatf("u%0d_rst", k));
        rst_v[k] = 1'b0; run_v[k] = 1'b0;
        for (int i = 0; i < 5; i++) step(k, '0, $sformatf("u%0d_idle", k));

        for (int i = 0; i < 18; i++) do_instr(k, mw, dir[i], dnz[i]);
        for (int i = 0; i < 60; i++) begin
            r_ir = 16'($urandom);
            if (r_ir[15:12] == 4'hF && r_ir[7:0] == 8'h25) r_ir[0] = 1'b0;
            do_instr(k, mw, r_ir, 3'($urandom));
        end

        // Reset in the middle of an LD data access
        if (mw > 0) begin
            ir_v[k] = 16'h2005; run_v[k] = 1'b1;
            build(16'h2005, 3'b000, mw, h);
            for (int i = 0; i < mw + 3; i++)
                step(k, exp_q[i], $sformatf("u%0d_ldpre_c%0d", k, i));
            rst_v[k] = 1'b1;
            step(k, '0, $sformatf("u%0d_rst_mid", k));
            rst_v[k] = 1'b0; run_v[k] = 1'b0;
            for (int i = 0; i < 3; i++) step(k, '0, $sformatf("u%0d_after_rst", k));
            do_instr(k, mw, 16'h1042, 3'b000);
        end

        // HALT: sticky regardless of run, released only by reset
        ir_v[k] = 16'hF025; run_v[k] = 1'b1;
        build(16'hF025, 3'b000, mw, h);
        for (int i = 0; i < exp_q.size(); i++)
            step(k, exp_q[i], $sformatf("u%0d_halt_entry_c%0d", k, i));
        hv = '0; hv.halted = 1'b1;
        for (int i = 0; i < 20; i++) begin
            run_v[k] = 1'($urandom_range(0, 1));
            step(k, hv, $sformatf("u%0d_halted", k));
        end
        rst_v[k] = 1'b1;
        step(k, '0, $sformatf("u%0d_halt_rst", k));
        rst_v[k] = 1'b0; run_v[k] = 1'b0;
        step(k, '0, $sformatf("u%0d_post_halt", k));
        do_instr(k, mw, 16'h1042, 3'b000);
        rst_v[k] = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_v[k] = 1'b1; run_v[k] = 1'b0; ir_v[k] = 16'h0000; nzp_v[k] = 3'b000;
        end
        run_stream(0, 0);
        run_stream(1, 2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/punc_control_ws.md
Name: punc_control_ws

Overview:
Multi-cycle LC3 control FSM for the PUnC processor, generalised with a parametrised memory wait-state count and a run/stall gate. It drives all datapath selects and enables: memory, register file, IR, PC, condition codes and the memory data latch. It decodes the full LC3 subset (ADD, AND, NOT, BR, JMP, JSR/JSRR, LD, LDR, LDI, LEA, ST, STR, STI, TRAP HALT) and sits between the datapath status signals and the datapath control inputs.

Parameters:
MEM_WAIT, 0, extra cycles each memory read/write access state is held (0..15).
HALT_VECT, 8'h25, TRAP vector that enters HALT.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
run  input  1  1 = allow leaving FETCH; 0 = stall in FETCH with no side effects
ir  input  16  current instruction register value
nzp  input  3  condition-code register {n,z,p}
mem_r_addr_sel  output  2  0=PC, 1=PC+sext(off9), 2=BaseR+sext(off6), 3=MDR
mem_w_en  output  1  memory write strobe
mem_w_addr_sel  output  2  same encoding as mem_r_addr_sel
mdr_ld  output  1  latch memory read data into MDR (LDI/STI pointer)
rf_w_en  output  1  register-file write enable
rf_w_addr_sel  output  1  0=ir[11:9], 1=R7
rf_w_data_sel  output  2  0=ALU, 1=mem data, 2=PC+sext(off9) (LEA), 3=PC (JSR link)
rf_r0_addr_sel  output  1  0=ir[8:6], 1=ir[11:9] (store source)
alu_op  output  2  0=ADD, 1=AND, 2=NOT, 3=pass
cc_ld  output  1  load condition codes from rf write data
ir_ld  output  1  load IR from memory
pc_ld  output  1  load PC
pc_sel  output  2  0=PC+1, 1=PC+sext(off9), 2=PC+sext(off11), 3=BaseR
halted  output  1  high in HALT
instr_done  output  1  one-cycle pulse on the last cycle of each instruction

Behaviour:
- All outputs default 0 every cycle unless listed below; combinational from state, wcnt and ir.
- Reset: state=FETCH, wcnt=0; on the following cycle all outputs are 0 except mem_r_addr_sel=0.
- States: FETCH, DECODE, EXEC, IND (second access of LDI/STI), HALT. Wait counter wcnt is 4 bits.
- Memory-access states (FETCH; EXEC of LD/LDR/LDI/ST/STR/STI; IND) dwell MEM_WAIT+1 cycles.
  - wcnt counts 0..MEM_WAIT; it clears on each state change.
  - Enables and strobes (ir_ld, pc_ld, mdr_ld, rf_w_en, cc_ld, mem_w_en) assert only on the final cycle (wcnt==MEM_WAIT).
  - Address selects are held for the whole dwell.
- FETCH:
  - If run=0: stay in FETCH, wcnt holds at 0, no strobes.
  - Else: mem_r_addr_sel=0. On the final cycle assert ir_ld=1, pc_ld=1, pc_sel=0, then go to DECODE.
- DECODE: one cycle, no strobes. If opcode is 1111 with ir[7:0]==HALT_VECT, go to HALT; else go to EXEC.
- EXEC by opcode:
  - ADD(0001) / AND(0101) / NOT(1001): alu_op=0/1/2, rf_w_en, cc_ld, data_sel=0. 1 cycle.
  - BR(0000): if (ir[11:9] & nzp)!=0, assert pc_ld with pc_sel=1. 1 cycle.
  - JMP(1100): pc_ld, pc_sel=3. 1 cycle.
  - JSR(0100): rf_w_en, addr_sel=1, data_sel=3, pc_ld, pc_sel = ir[11] ? 2 : 3. 1 cycle. R7 receives the old (already incremented) PC.
  - LEA(1110): rf_w_en, data_sel=2, cc_ld. 1 cycle.
  - LD(0010) / LDR(0110): mem_r_addr_sel=1/2. Final cycle: rf_w_en, data_sel=1, cc_ld.
  - ST(0011) / STR(0111): mem_w_addr_sel=1/2, rf_r0_addr_sel=1, alu_op=3. mem_w_en on the final cycle only.
  - LDI(1010) / STI(1011): mem_r_addr_sel=1, mdr_ld on the final cycle, then go to IND.
  - Other opcodes, including non-HALT TRAP, 1000 and 1101: NOP, 1 cycle.
- IND:
  - LDI: mem_r_addr_sel=3. Final cycle: rf_w_en, data_sel=1, cc_ld.
  - STI: mem_w_addr_sel=3, rf_r0_addr_sel=1, alu_op=3. mem_w_en on the final cycle.
- Leaving EXEC or IND (final cycle, not going to IND): instr_done=1, next state FETCH.
- HALT: halted=1, all strobes 0. Leaves only via rst. run is ignored.
- rst has priority in every state including mid-wait. The next state is FETCH and no strobe fires in the reset cycle.
- run is sampled only in FETCH at wcnt==0. Deasserting it mid-instruction has no effect until the next FETCH.

Test Plan:
- Reset, MEM_WAIT=0, run=1, ir=16'h1042 (ADD R0,R1,R2) -> FETCH(ir_ld,pc_ld), DECODE, EXEC(rf_w_en,cc_ld,alu_op=0,instr_done). Period 3 cycles, repeating.
- MEM_WAIT=2, ir=16'h2005 (LD) -> FETCH 3 cycles with ir_ld only on cycle 3. EXEC 3 cycles with mem_r_addr_sel=1 throughout, rf_w_en/data_sel=1 only on cycle 3. Total 7 cycles.
- BR ir=16'h0403 (BRz): nzp=3'b010 -> pc_ld=1, pc_sel=1 in EXEC. nzp=3'b001 -> pc_ld=0.
- ir=16'hA005 (LDI), MEM_WAIT=1 -> EXEC 2 cycles (mdr_ld on 2nd), then IND 2 cycles with mem_r_addr_sel=3 and rf_w_en on 2nd, then FETCH.
- ir=16'hF025 -> DECODE then HALT with halted=1 held for 20 cycles despite run toggling. rst returns to FETCH, halted=0.
- run=0 after reset for 5 cycles -> no ir_ld/pc_ld pulses. Assert rst during LD wait cycle 2 -> no rf_w_en ever fires, state is FETCH next cycle.
